// File: rtl/alu_pkg.sv
// Shared definitions for the sequential add/subtract unit: flag bit
// positions, FSM state type and parameter helpers.
package alu_pkg;

  // Bit positions inside the 4-bit flags vector.
  localparam int FLAG_V = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Number of chunk cycles one operation takes.
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Legal geometry: at least one whole chunk and no partial chunk.
  function automatic bit width_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/seq_add_sub_flags_chunk_adder.sv
// Combinational CHUNK-bit adder slice with carry in/out; the top level
// reuses a single instance on every cycle of an operation.
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/seq_add_sub_flags.sv
// Multi-cycle add/subtract unit. Operands are consumed CHUNK bits per
// clock, least-significant chunk first, with the carry held in a register
// between chunks. Result and V/N/Z/C flags update only on the done edge.
//
// Handshake: start is sampled only while busy=0 (IDLE). The accepting
// edge latches a, b (inverted for subtract), sign and the carry-in, and
// raises busy. After NCHUNK further edges busy drops and done pulses for
// exactly one cycle together with the new result/flags. start while busy
// is dropped (no queueing); start during the done cycle is accepted, so
// operations can run back to back without a gap.
module seq_add_sub_flags
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic             use_carry,
  input  logic             cin,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if (!width_ok(WIDTH, CHUNK)) begin : g_bad_geometry
    $error("seq_add_sub_flags: WIDTH must be a non-zero multiple of CHUNK");
  end

  // FSM state is kept as a named signal so checkers can bind to it.
  state_t           state;
  state_t           state_nx;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic             sign_q;
  logic [CHUNK-1:0] csum;
  logic             cout;
  logic [WIDTH-1:0] full_sum;
  logic [3:0]       flags_nx;
  logic             accept;
  logic             last;

  assign accept = (state == IDLE) && start;
  assign last   = (state == BUSY) && (idx == LAST_IDX);
  assign busy   = (state == BUSY);

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a    (a_sh[CHUNK-1:0]),
    .b    (b_sh[CHUNK-1:0]),
    .cin  (carry),
    .sum  (csum),
    .cout (cout)
  );

  // Lower chunks finished on earlier cycles wait here; the full sum is the
  // current chunk on top of them, which is only complete on the last cycle.
  if (NCHUNK == 1) begin : g_single
    assign full_sum = csum;
  end else begin : g_multi
    logic [WIDTH-CHUNK-1:0] acc;
    assign full_sum = {csum, acc};
    if (NCHUNK == 2) begin : g_two
      // Accumulate the finished low chunk.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    acc <= '0;
        else if (busy && !last)        acc <= csum;
      end
    end else begin : g_many
      // Shift finished chunks down, newest at the top.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    acc <= '0;
        else if (busy && !last)        acc <= {csum, acc[WIDTH-CHUNK-1:CHUNK]};
      end
    end
  end

  // Flags of the completed operation; a_sh/b_sh hold the top chunk on the
  // last cycle, so their bit CHUNK-1 is the operand sign bit.
  always_comb begin
    flags_nx         = '0;
    flags_nx[FLAG_C] = cout;
    flags_nx[FLAG_Z] = (full_sum == '0);
    flags_nx[FLAG_N] = sign_q && full_sum[WIDTH-1];
    flags_nx[FLAG_V] = sign_q && (a_sh[CHUNK-1] == b_sh[CHUNK-1]) &&
                       (full_sum[WIDTH-1] != a_sh[CHUNK-1]);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state: accept in IDLE, leave BUSY after the last chunk.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = BUSY;
      BUSY:    if (idx == LAST_IDX) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture, per-chunk carry chain, result/flag update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      carry  <= 1'b0;
      sign_q <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      flags  <= 4'b0000;
    end else begin
      done <= 1'b0;
      if (accept) begin
        idx    <= '0;
        a_sh   <= a;
        b_sh   <= op_sub ? ~b : b;
        carry  <= use_carry ? cin : op_sub;
        sign_q <= sign;
      end else if (busy) begin
        idx   <= idx + IDXW'(1);
        a_sh  <= a_sh >> CHUNK;
        b_sh  <= b_sh >> CHUNK;
        carry <= cout;
        if (last) begin
          done   <= 1'b1;
          result <= full_sum;
          flags  <= flags_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_add_sub_flags.sv
// Bench for seq_add_sub_flags: an 8-bit/4-bit-chunk instance and a
// 32-bit/8-bit-chunk instance, directed cases plus random operations
// checked against an arithmetic reference model.
module tb_seq_add_sub_flags;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // index 0 -> 8-bit instance, index 1 -> 32-bit instance
  logic        start_v [2];
  logic        op_sub_v[2];
  logic        uc_v    [2];
  logic        cin_v   [2];
  logic        sign_v  [2];
  logic [31:0] a_v     [2];
  logic [31:0] b_v     [2];

  logic        busy8, done8, busy32, done32;
  logic [7:0]  res8;
  logic [31:0] res32;
  logic [3:0]  flags8, flags32;

  logic [31:0] res_v  [2];
  logic [3:0]  flags_v[2];
  logic        done_v [2];
  logic        busy_v [2];

  assign res_v[0]   = {24'h0, res8};
  assign res_v[1]   = res32;
  assign flags_v[0] = flags8;
  assign flags_v[1] = flags32;
  assign done_v[0]  = done8;
  assign done_v[1]  = done32;
  assign busy_v[0]  = busy8;
  assign busy_v[1]  = busy32;

  seq_add_sub_flags #(.WIDTH(8), .CHUNK(4)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_v[0]),
    .op_sub    (op_sub_v[0]),
    .use_carry (uc_v[0]),
    .cin       (cin_v[0]),
    .sign      (sign_v[0]),
    .a         (a_v[0][7:0]),
    .b         (b_v[0][7:0]),
    .busy      (busy8),
    .done      (done8),
    .result    (res8),
    .flags     (flags8)
  );

  seq_add_sub_flags #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_v[1]),
    .op_sub    (op_sub_v[1]),
    .use_carry (uc_v[1]),
    .cin       (cin_v[1]),
    .sign      (sign_v[1]),
    .a         (a_v[1]),
    .b         (b_v[1]),
    .busy      (busy32),
    .done      (done32),
    .result    (res32),
    .flags     (flags32)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  // Returns {C, Z, N, V, result[31:0]} from plain integer arithmetic.
  function automatic logic [35:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic sub, input logic uc, input logic ci,
                                        input logic sg);
    longint unsigned m, av, bp, c, full, r;
    longint half, sa, sb, s;
    logic cf, zf, nf, vf;
    m    = (64'd1 << w) - 64'd1;
    av   = {32'h0, a} & m;
    bp   = {32'h0, (sub ? ~b : b)} & m;
    c    = (uc ? ci : sub) ? 64'd1 : 64'd0;
    full = av + bp + c;
    r    = full & m;
    cf   = ((full >> w) & 64'd1) != 0;
    zf   = (r == 0);
    half = longint'(64'd1 << (w - 1));
    sa   = (longint'(av) >= half) ? longint'(av) - 2 * half : longint'(av);
    sb   = (longint'(bp) >= half) ? longint'(bp) - 2 * half : longint'(bp);
    s    = sa + sb + longint'(c);
    vf   = sg && ((s > half - 1) || (s < -half));
    nf   = sg && (((r >> (w - 1)) & 64'd1) != 0);
    return {cf, zf, nf, vf, r[31:0]};
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge; pulses start, then scrambles the operand inputs
  // and follows the operation until done (bounded). hs_ok reports that busy
  // stayed high and result/flags stayed frozen until the done cycle.
  task automatic run_op(input int u, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic uc, input logic ci, input logic sg,
                        output logic [31:0] r, output logic [3:0] f,
                        output int lat, output bit hs_ok);
    logic [31:0] r0;
    logic [3:0]  f0;
    a_v[u] = a; b_v[u] = b; op_sub_v[u] = sub; uc_v[u] = uc; cin_v[u] = ci;
    sign_v[u] = sg; start_v[u] = 1'b1;
    r0 = res_v[u];
    f0 = flags_v[u];
    @(negedge clk);
    start_v[u] = 1'b0;
    a_v[u] = $urandom; b_v[u] = $urandom; op_sub_v[u] = $urandom_range(0, 1);
    uc_v[u] = $urandom_range(0, 1); cin_v[u] = $urandom_range(0, 1);
    sign_v[u] = $urandom_range(0, 1);
    lat = 0;
    hs_ok = 1'b1;
    while (done_v[u] !== 1'b1 && lat < 20) begin
      if (busy_v[u] !== 1'b1 || res_v[u] !== r0 || flags_v[u] !== f0) hs_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (busy_v[u] !== 1'b0) hs_ok = 1'b0;
    r = res_v[u];
    f = flags_v[u];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy8, done8, res8, flags8, busy32, done32, res32, flags32} !== '0) begin
      n_err++;
      $display("FAIL reset_held: got b8=%b d8=%b r8=%h f8=%b b32=%b d32=%b r32=%h f32=%b, want all 0",
               busy8, done8, res8, flags8, busy32, done32, res32, flags32);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({busy8, done8, res8, flags8, busy32, done32, res32, flags32} !== '0) begin
      n_err++;
      $display("FAIL reset_released: got b8=%b d8=%b r8=%h f8=%b r32=%h f32=%b, want all 0",
               busy8, done8, res8, flags8, res32, flags32);
    end
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic sub, uc, ci, sg;
    logic [7:0] er;
    logic [3:0] ef;
  } dcase_t;

  task automatic test_directed();
    dcase_t tbl[6];
    logic [31:0] r;
    logic [3:0] f;
    int lat;
    bit ok;
    tbl[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80, 4'b0011};
    tbl[1] = '{8'h80, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 8'h7F, 4'b1001};
    tbl[2] = '{8'h05, 8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 4'b1100};
    tbl[3] = '{8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'b1100};
    tbl[4] = '{8'h0F, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h10, 4'b0000};
    tbl[5] = '{8'hF0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hE0, 4'b1010};
    for (int i = 0; i < 6; i++) begin
      repeat (i % 2) @(negedge clk);
      run_op(0, {24'h0, tbl[i].a}, {24'h0, tbl[i].b}, tbl[i].sub, tbl[i].uc, tbl[i].ci,
             tbl[i].sg, r, f, lat, ok);
      n_vec++;
      if (r !== {24'h0, tbl[i].er} || f !== tbl[i].ef) begin
        n_err++;
        $display("FAIL directed[%0d]: got result=%h flags=%b, want result=%h flags=%b",
                 i, r, f, tbl[i].er, tbl[i].ef);
      end
      n_vec++;
      if (lat !== 2 || ok !== 1'b1) begin
        n_err++;
        $display("FAIL directed_timing[%0d]: got latency=%0d handshake_ok=%0d, want 2 and 1",
                 i, lat, ok);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int n;
    int extra;
    @(negedge clk);
    a_v[0] = 32'h10; b_v[0] = 32'h20; op_sub_v[0] = 0; uc_v[0] = 0; cin_v[0] = 0;
    sign_v[0] = 0; start_v[0] = 1'b1;
    @(negedge clk);
    // second request while busy: must be dropped
    a_v[0] = 32'hAA; b_v[0] = 32'h11; op_sub_v[0] = 1; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    n = 1;
    while (done8 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (n !== 2 || res8 !== 8'h30 || flags8 !== 4'b0000) begin
      n_err++;
      $display("FAIL busy_ignore: got latency=%0d result=%h flags=%b, want 2 30 0000",
               n, res8, flags8);
    end
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (done8 !== 1'b0 || busy8 !== 1'b0) extra++;
    end
    n_vec++;
    if (extra !== 0 || res8 !== 8'h30) begin
      n_err++;
      $display("FAIL busy_no_queue: got %0d extra busy/done cycles result=%h, want 0 and 30",
               extra, res8);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2;
    logic [3:0] f1, f2;
    int l1, l2;
    bit ok1, ok2;
    // second run_op starts in the done cycle of the first
    run_op(0, 32'h22, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0, r1, f1, l1, ok1);
    run_op(0, 32'h22, 32'h33, 1'b1, 1'b0, 1'b0, 1'b1, r2, f2, l2, ok2);
    n_vec++;
    if (r1 !== 32'h33 || f1 !== 4'b0000) begin
      n_err++;
      $display("FAIL b2b_first: got result=%h flags=%b, want 33 0000", r1, f1);
    end
    n_vec++;
    if (r2 !== 32'hEF || f2 !== 4'b0010 || l2 !== 2 || ok2 !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_second: got result=%h flags=%b latency=%0d hs=%0d, want EF 0010 2 1",
               r2, f2, l2, ok2);
    end
  endtask

  task automatic test_reset_mid_busy();
    int dones;
    @(negedge clk);
    a_v[0] = 32'h01; b_v[0] = 32'h02; op_sub_v[0] = 0; uc_v[0] = 0; sign_v[0] = 0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy8, done8, res8, flags8} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_busy: got busy=%b done=%b result=%h flags=%b, want all 0",
               busy8, done8, res8, flags8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (done8 !== 1'b0 || busy8 !== 1'b0) dones++;
    end
    n_vec++;
    if (dones !== 0 || res8 !== 8'h00) begin
      n_err++;
      $display("FAIL reset_no_done: got %0d busy/done cycles result=%h, want 0 and 00",
               dones, res8);
    end
  endtask

  task automatic test_wide();
    logic [31:0] r;
    logic [3:0] f;
    int lat;
    bit ok;
    run_op(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, r, f, lat, ok);
    n_vec++;
    if (r !== 32'h0 || f !== 4'b1100 || lat !== 4 || ok !== 1'b1) begin
      n_err++;
      $display("FAIL wide_wrap: got result=%h flags=%b latency=%0d hs=%0d, want 0 1100 4 1",
               r, f, lat, ok);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r;
    logic [3:0] f;
    logic [35:0] exp;
    logic sub, uc, ci, sg;
    int lat, w;
    bit ok;
    for (int i = 0; i < 60; i++) begin
      int u;
      u = i % 2;
      w = (u == 0) ? 8 : 32;
      a = $urandom; b = $urandom;
      if (u == 0) begin a = a & 32'hFF; b = b & 32'hFF; end
      case ($urandom_range(0, 3))
        0: a = (u == 0) ? 32'hFF : 32'hFFFF_FFFF;
        1: b = a;
        default: ;
      endcase
      sub = $urandom_range(0, 1); uc = $urandom_range(0, 1);
      ci = $urandom_range(0, 1); sg = $urandom_range(0, 1);
      exp = model(w, a, b, sub, uc, ci, sg);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(u, a, b, sub, uc, ci, sg, r, f, lat, ok);
      n_vec++;
      if (r !== exp[31:0] || f !== exp[35:32]) begin
        n_err++;
        $display("FAIL random[%0d] w=%0d a=%h b=%h sub=%b uc=%b cin=%b sg=%b: got %h/%b, want %h/%b",
                 i, w, a, b, sub, uc, ci, sg, r, f, exp[31:0], exp[35:32]);
      end
      n_vec++;
      if (lat !== w / ((u == 0) ? 4 : 8) || ok !== 1'b1) begin
        n_err++;
        $display("FAIL random_timing[%0d]: got latency=%0d hs=%0d, want %0d and 1",
                 i, lat, ok, w / ((u == 0) ? 4 : 8));
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 0; op_sub_v[i] = 0; uc_v[i] = 0; cin_v[i] = 0; sign_v[i] = 0;
      a_v[i] = 0; b_v[i] = 0;
    end
    test_reset();
    test_directed();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_busy();
    test_wide();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
